// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the write-beat record passed from
// the capture front end to the bridge core.
package ahb_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } hburst_t;

    typedef enum logic [2:0] {
        BYTE       = 3'b000,
        HALFWORD   = 3'b001,
        WORD       = 3'b010,
        DOUBLEWORD = 3'b011,
        FOURWORD   = 3'b100,
        EIGHTWORD  = 3'b101
    } hsize_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DP_NONE,
        DP_WRITE,
        ERR1,
        ERR2
    } dp_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        hsize_t            size;
        hburst_t           burst;
        logic              first;
    } wr_beat_t;

endpackage

// File: rtl/ahb_wr_capture_if.sv
// AHB slave-side signals plus the buffered write-beat stream.
interface ahb_wr_capture_if #(
    parameter int AHB_DATA_WIDTH    = 64,
    parameter int AHB_ADDRESS_WIDTH = 32
);
    logic                           HSEL;
    logic [AHB_ADDRESS_WIDTH-1:0]   HADDR;
    logic [AHB_DATA_WIDTH-1:0]      HWDATA;
    logic                           HWRITE;
    logic [2:0]                     HSIZE;
    logic [2:0]                     HBURST;
    logic [1:0]                     HTRANS;
    logic                           HREADY;
    logic                           HREADYOUT;
    logic                           HRESP;
    logic                           out_valid;
    logic                           out_ready;
    logic [AHB_ADDRESS_WIDTH-1:0]   out_addr;
    logic [AHB_DATA_WIDTH-1:0]      out_data;
    logic [AHB_DATA_WIDTH/8-1:0]    out_strb;
    logic [2:0]                     out_size;
    logic [2:0]                     out_burst;
    logic                           out_first;

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST,
        input  HTRANS, HREADY, out_ready,
        output HREADYOUT, HRESP, out_valid, out_addr,
        output out_data, out_strb, out_size, out_burst, out_first
    );

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST,
        output HTRANS, HREADY, out_ready,
        input  HREADYOUT, HRESP, out_valid, out_addr,
        input  out_data, out_strb, out_size, out_burst, out_first
    );

endinterface

// File: rtl/ahb_wr_fifo.sv
// Show-ahead FIFO of write beats; the head is visible whenever
// the FIFO is non-empty and stays put until popped.
module ahb_wr_fifo
    import ahb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  wr_beat_t                 push_beat,
    input  logic                     pop,
    output wr_beat_t                 head,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    wr_beat_t       mem [DEPTH];
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic           do_push;
    logic           do_pop;

    assign do_push    = push && (count != FULL);
    assign do_pop     = pop && (count != '0);
    assign head       = mem[rptr];
    assign head_valid = (count != '0);

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_beat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ahb_wr_capture.sv
// AHB write front end: pairs address and data phases, builds
// byte strobes and buffers beats; waits when full, errors on reads.
module ahb_wr_capture
    import ahb_pkg::*;
#(
    parameter int AHB_DATA_WIDTH    = 64,
    parameter int AHB_ADDRESS_WIDTH = 32,
    parameter int FIFO_DEPTH        = 8
) (
    input logic             HCLK,
    input logic             HRESETn,
    ahb_wr_capture_if.slave bus
);
    localparam int SW = AHB_DATA_WIDTH / 8;
    localparam int LW = $clog2(SW);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    dp_state_t                      state;
    dp_state_t                      state_nx;
    logic [AHB_ADDRESS_WIDTH-1:0]   a_addr;
    logic [AHB_ADDRESS_WIDTH-1:0]   addr_d;
    logic [SW-1:0]                  a_strb;
    logic [SW-1:0]                  strb_d;
    hsize_t                         a_size;
    hburst_t                        a_burst;
    logic                           a_first;
    logic [LW:0]                    nb;
    logic [LW-1:0]                  lane_mask;
    logic [LW-1:0]                  lane;
    logic                           accept;
    logic                           legal;
    logic                           full;
    logic                           ready;
    logic                           resp;
    logic                           push;
    logic [CW-1:0]                  count;
    wr_beat_t                       push_beat;
    wr_beat_t                       head;
    logic                           head_valid;

    assign accept = bus.HSEL && bus.HREADY && bus.HTRANS[1];
    assign legal  = bus.HWRITE && (bus.HSIZE <= 3'(LW));
    assign full   = (count == FULL);
    assign push   = (state == DP_WRITE) && !full;

    // Strobe and alignment are only meaningful for legal sizes,
    // which is the only case in which they reach the FIFO.
    always_comb begin
        nb        = (LW+1)'(1) << bus.HSIZE;
        lane_mask = ~LW'(nb - 1'b1);
        lane      = bus.HADDR[LW-1:0] & lane_mask;
        addr_d    = {bus.HADDR[AHB_ADDRESS_WIDTH-1:LW], lane};
        for (int i = 0; i < SW; i++) begin
            strb_d[i] = (i >= int'(lane)) &&
                        (i < int'(lane) + int'(nb));
        end
    end

    always_comb begin
        ready    = 1'b1;
        resp     = HRESP_OKAY;
        state_nx = state;
        unique case (state)
            DP_NONE:  ;
            DP_WRITE: ready = !full;
            ERR1: begin
                ready = 1'b0;
                resp  = HRESP_ERROR;
            end
            ERR2:     resp = HRESP_ERROR;
        endcase
        if (state == ERR1) begin
            state_nx = ERR2;
        end else if (ready) begin
            if (!accept)    state_nx = DP_NONE;
            else if (legal) state_nx = DP_WRITE;
            else            state_nx = ERR1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= DP_NONE;
            a_addr  <= '0;
            a_strb  <= '0;
            a_size  <= BYTE;
            a_burst <= SINGLE;
            a_first <= 1'b0;
        end else begin
            state <= state_nx;
            if (ready && accept) begin
                a_addr  <= addr_d;
                a_strb  <= strb_d;
                a_size  <= hsize_t'(bus.HSIZE);
                a_burst <= hburst_t'(bus.HBURST);
                a_first <= (htrans_t'(bus.HTRANS) == NONSEQ);
            end
        end
    end

    always_comb begin
        push_beat       = '0;
        push_beat.addr  = a_addr;
        push_beat.data  = bus.HWDATA;
        push_beat.strb  = a_strb;
        push_beat.size  = a_size;
        push_beat.burst = a_burst;
        push_beat.first = a_first;
    end

    ahb_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (HCLK),
        .rst_n      (HRESETn),
        .push       (push),
        .push_beat  (push_beat),
        .pop        (bus.out_ready),
        .head       (head),
        .head_valid (head_valid),
        .count      (count)
    );

    assign bus.HREADYOUT = ready;
    assign bus.HRESP     = resp;
    assign bus.out_valid = head_valid;
    assign bus.out_addr  = head.addr;
    assign bus.out_data  = head.data;
    assign bus.out_strb  = head.strb;
    assign bus.out_size  = head.size;
    assign bus.out_burst = head.burst;
    assign bus.out_first = head.first;

endmodule

// File: tb/tb_ahb_wr_capture.sv
// Bench for ahb_wr_capture: AHB master model, transfer-level
// reference of the beat stream and wait/error responses.
module tb_ahb_wr_capture;
    import ahb_pkg::*;

    localparam int DEPTH = 8;
    localparam int K_NONE = 0;
    localparam int K_WR   = 1;
    localparam int K_E1   = 2;
    localparam int K_E2   = 3;

    typedef struct {
        bit        sel;
        bit [1:0]  trans;
        bit        write;
        bit [2:0]  size;
        bit [2:0]  burst;
        bit [31:0] addr;
        bit [63:0] data;
    } xfer_t;

    typedef struct {
        bit [31:0] addr;
        bit [63:0] data;
        bit [7:0]  strb;
        bit [2:0]  size;
        bit [2:0]  burst;
        bit        first;
    } beat_t;

    typedef struct {
        bit [31:0] addr;
        bit [2:0]  size;
        bit [63:0] data;
        bit [31:0] exp_addr;
        bit [7:0]  exp_strb;
    } vec_t;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_wr_capture_if #(
        .AHB_DATA_WIDTH    (64),
        .AHB_ADDRESS_WIDTH (32)
    ) bus ();

    assign bus.HREADY = bus.HREADYOUT;

    ahb_wr_capture #(
        .AHB_DATA_WIDTH    (64),
        .AHB_ADDRESS_WIDTH (32),
        .FIFO_DEPTH        (DEPTH)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    int    n_tests = 0;
    int    n_fail = 0;
    int    n_popped = 0;
    int    rdy_pct = 100;
    int    dpk = K_NONE;
    xfer_t dpx;
    xfer_t xq[$];
    beat_t expq[$];
    beat_t last_beat;

    task automatic check(string name, logic [63:0] act,
                         logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    function automatic beat_t expect_beat(xfer_t x);
        beat_t b;
        int nb;
        int lane;
        nb      = 1 << x.size;
        lane    = int'(x.addr[2:0]) & ~(nb - 1);
        b.addr  = x.addr & ~(32'(nb - 1));
        b.data  = x.data;
        b.strb  = 8'(((1 << nb) - 1) << lane);
        b.size  = x.size;
        b.burst = x.burst;
        b.first = (x.trans == 2'b10);
        return b;
    endfunction

    function automatic xfer_t mk(bit [1:0] tr, bit wr, bit [2:0] sz,
                                 bit [2:0] bu, bit [31:0] ad,
                                 bit [63:0] d);
        xfer_t x;
        x.sel = 1'b1; x.trans = tr; x.write = wr;
        x.size = sz; x.burst = bu; x.addr = ad; x.data = d;
        return x;
    endfunction

    task automatic drive_idle();
        bus.HSEL = 0; bus.HTRANS = 0; bus.HWRITE = 0;
        bus.HSIZE = 0; bus.HBURST = 0; bus.HADDR = 0;
        bus.HWDATA = 0; bus.out_ready = 0;
    endtask

    // One bus cycle: drive at negedge, check, advance the model.
    task automatic step();
        xfer_t a;
        beat_t b;
        bit    exp_rdy;
        bit    exp_resp;
        a = '{default: 0};
        if (xq.size() != 0) a = xq[0];
        bus.HSEL   = a.sel;
        bus.HTRANS = a.trans;
        bus.HWRITE = a.write;
        bus.HSIZE  = a.size;
        bus.HBURST = a.burst;
        bus.HADDR  = a.addr;
        bus.HWDATA = (dpk == K_WR) ? dpx.data : 64'hDEADBEEF_0BADF00D;
        bus.out_ready = ($urandom_range(99) < rdy_pct);
        #1;
        exp_rdy  = (dpk == K_WR) ? (expq.size() < DEPTH) : (dpk != K_E1);
        exp_resp = (dpk == K_E1) || (dpk == K_E2);
        check("hreadyout", bus.HREADYOUT, exp_rdy);
        check("hresp", bus.HRESP, exp_resp);
        check("out_valid", bus.out_valid, expq.size() != 0);
        if (bus.out_valid && bus.out_ready && expq.size() != 0) begin
            b = expq.pop_front();
            last_beat.addr  = bus.out_addr;
            last_beat.data  = bus.out_data;
            last_beat.strb  = bus.out_strb;
            last_beat.size  = bus.out_size;
            last_beat.burst = bus.out_burst;
            last_beat.first = bus.out_first;
            check("beat_addr", bus.out_addr, b.addr);
            check("beat_data", bus.out_data, b.data);
            check("beat_strb", bus.out_strb, b.strb);
            check("beat_size", bus.out_size, b.size);
            check("beat_burst", bus.out_burst, b.burst);
            check("beat_first", bus.out_first, b.first);
            n_popped++;
        end
        if (bus.HREADYOUT) begin
            if (dpk == K_WR) expq.push_back(expect_beat(dpx));
            if (a.sel && a.trans[1])
                dpk = (a.write && (1 << a.size) <= 64 / 8) ? K_WR : K_E1;
            else
                dpk = K_NONE;
            dpx = a;
            if (xq.size() != 0) void'(xq.pop_front());
        end else if (dpk == K_E1) begin
            dpk = K_E2;
        end
        @(negedge HCLK);
    endtask

    task automatic drain();
        rdy_pct = 100;
        for (int i = 0; i < 80; i++) begin
            if (expq.size() == 0 && xq.size() == 0 && dpk == K_NONE)
                break;
            step();
        end
        check("drained",
              (expq.size() != 0) || (xq.size() != 0) || (dpk != K_NONE),
              0);
    endtask

    task automatic rand_batch(int n, int pct);
        xfer_t x;
        for (int i = 0; i < n; i++) begin
            x.sel   = ($urandom_range(9) != 0);
            x.trans = 2'($urandom_range(3));
            x.write = ($urandom_range(9) != 0);
            x.size  = ($urandom_range(9) == 0) ? 3'($urandom_range(7))
                                               : 3'($urandom_range(3));
            x.burst = 3'($urandom_range(7));
            x.addr  = $urandom;
            x.data  = {$urandom, $urandom};
            xq.push_back(x);
        end
        rdy_pct = pct;
        for (int i = 0; i < 20 * n && xq.size() != 0; i++) step();
        drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[8];
        int p0;
        int n;
        vt[0] = '{32'h4,  3'd2, 64'h0706050403020100, 32'h4,  8'hF0};
        vt[1] = '{32'h5,  3'd0, 64'h1111111111111111, 32'h5,  8'h20};
        vt[2] = '{32'h7,  3'd1, 64'h2222222222222222, 32'h6,  8'hC0};
        vt[3] = '{32'h3,  3'd3, 64'h3333333333333333, 32'h0,  8'hFF};
        vt[4] = '{32'h0,  3'd0, 64'h4444444444444444, 32'h0,  8'h01};
        vt[5] = '{32'h12, 3'd1, 64'h5555555555555555, 32'h12, 8'h0C};
        vt[6] = '{32'h9,  3'd2, 64'h6666666666666666, 32'h8,  8'h0F};
        vt[7] = '{32'h2E, 3'd2, 64'h7777777777777777, 32'h2C, 8'hF0};

        drive_idle();
        repeat (3) @(negedge HCLK);
        check("rst_hreadyout", bus.HREADYOUT, 1);
        check("rst_hresp", bus.HRESP, 0);
        check("rst_out_valid", bus.out_valid, 0);
        HRESETn = 1'b1;
        @(negedge HCLK);

        // single writes of each size and alignment
        for (int i = 0; i < 8; i++) begin
            p0 = n_popped;
            xq.push_back(mk(2'b10, 1, vt[i].size, 3'b000,
                            vt[i].addr, vt[i].data));
            drain();
            check("vec_count", n_popped - p0, 1);
            check("vec_addr", last_beat.addr, vt[i].exp_addr);
            check("vec_strb", last_beat.strb, vt[i].exp_strb);
            check("vec_data", last_beat.data, vt[i].data);
            check("vec_first", last_beat.first, 1);
        end

        // INCR16 doublewords into a consumer that is stalled
        p0 = n_popped;
        for (int i = 0; i < 16; i++)
            xq.push_back(mk(i == 0 ? 2'b10 : 2'b11, 1, 3'd3, 3'b111,
                            32'h100 + 32'(8 * i), {$urandom, $urandom}));
        rdy_pct = 0;
        n = 0;
        while (bus.HREADYOUT && n < 30) begin
            step();
            n++;
        end
        check("incr16_stall_cycle", n, 9);
        step();
        step();
        rdy_pct = 100;
        step();
        rdy_pct = 0;
        check("incr16_release", bus.HREADYOUT, 1);
        step();
        check("incr16_restall", bus.HREADYOUT, 0);
        drain();
        check("incr16_count", n_popped - p0, 16);

        // INCR4 words with a BUSY cycle inside the burst
        p0 = n_popped;
        xq.push_back(mk(2'b10, 1, 3'd2, 3'b011, 32'h0, 64'hA0));
        xq.push_back(mk(2'b11, 1, 3'd2, 3'b011, 32'h4, 64'hA1));
        xq.push_back(mk(2'b01, 1, 3'd2, 3'b011, 32'h8, 64'hFF));
        xq.push_back(mk(2'b11, 1, 3'd2, 3'b011, 32'h8, 64'hA2));
        xq.push_back(mk(2'b11, 1, 3'd2, 3'b011, 32'hC, 64'hA3));
        drain();
        check("busy_count", n_popped - p0, 4);
        check("busy_last_addr", last_beat.addr, 32'hC);
        check("busy_last_strb", last_beat.strb, 8'hF0);

        // read gets a two-cycle ERROR, following write is OKAY
        p0 = n_popped;
        rdy_pct = 100;
        xq.push_back(mk(2'b10, 0, 3'd2, 3'b000, 32'h10, 64'h0));
        xq.push_back(mk(2'b10, 1, 3'd2, 3'b000, 32'h20, 64'hBEEF));
        step();
        check("err1_hreadyout", bus.HREADYOUT, 0);
        check("err1_hresp", bus.HRESP, 1);
        step();
        check("err2_hreadyout", bus.HREADYOUT, 1);
        check("err2_hresp", bus.HRESP, 1);
        step();
        check("after_err_hresp", bus.HRESP, 0);
        check("after_err_hreadyout", bus.HREADYOUT, 1);
        drain();
        check("err_count", n_popped - p0, 1);
        check("err_addr", last_beat.addr, 32'h20);

        // asynchronous reset with three beats buffered
        for (int i = 0; i < 8; i++)
            xq.push_back(mk(i == 0 ? 2'b10 : 2'b11, 1, 3'd3, 3'b101,
                            32'h200 + 32'(8 * i), {$urandom, $urandom}));
        rdy_pct = 0;
        repeat (4) step();
        check("pre_rst_valid", bus.out_valid, 1);
        #2;
        HRESETn = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_hreadyout", bus.HREADYOUT, 1);
        check("mid_rst_hresp", bus.HRESP, 0);
        xq.delete();
        expq.delete();
        dpk = K_NONE;
        drive_idle();
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        p0 = n_popped;
        xq.push_back(mk(2'b10, 1, 3'd3, 3'b000, 32'h300, 64'hC0FFEE));
        drain();
        check("post_rst_count", n_popped - p0, 1);
        check("post_rst_addr", last_beat.addr, 32'h300);

        // random traffic against the reference model
        rand_batch(300, 60);
        rand_batch(300, 25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
